sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; multiple of 8, at least 8.
REQ-002 Parameter DEPTH, default 4096: number of words; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 32: byte-address width.
REQ-004 Parameter INIT_CLEAR, default 1: 1 zero-fills the array after reset; 0 skips the fill.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 req_i  in  1  request valid.
REQ-008 we_i  in  1  1 = write, 0 = read.
REQ-009 be_i  in  DATA_W/8  byte enables for writes; ignored for reads.
REQ-010 addr_i  in  ADDR_W  byte address.
REQ-011 data_i  in  DATA_W  write data.
REQ-012 gnt_o  out  1  request accepted this cycle.
REQ-013 rvalid_o  out  1  response valid.
REQ-014 rdata_o  out  DATA_W  read data; zero for writes and errors.
REQ-015 err_o  out  1  response carries an out-of-range error; qualified by rvalid_o.
REQ-016 rready_i  in  1  consumer accepts the response.
REQ-017 init_done_o  out  1  array ready for requests.

Function
REQ-018 Word index SHALL be addr_i[ADDR_W-1:log2(DATA_W/8)]; low address bits SHALL be ignored.
REQ-019 FSM SHALL have three states: INIT, READY and HOLD.
REQ-020 In INIT with INIT_CLEAR=1, a counter SHALL write zero to word 0..DEPTH-1, one word per cycle.
REQ-021 INIT SHALL move to READY after DEPTH fill cycles; with INIT_CLEAR=0 it SHALL move after 1 cycle.
REQ-022 In INIT, gnt_o SHALL be 0 and init_done_o SHALL be 0.
REQ-023 gnt_o SHALL be combinational, equal to req_i && init_done_o && (!rvalid_o || rready_i).
REQ-024 An accepted write SHALL update only the bytes with be_i set, on the accept edge.
REQ-025 A request with word index >= DEPTH SHALL not modify the array and SHALL respond with err_o=1 and rdata_o=0.
REQ-026 Latency SHALL be 1: a request granted in cycle N SHALL give rvalid_o=1 in cycle N+1, for reads and writes alike.
REQ-027 Read data SHALL be the word content after all earlier accepted writes; a read in cycle N+1 of a write granted in cycle N SHALL return the new data.
REQ-028 If rvalid_o=1 and rready_i=0, the FSM SHALL enter HOLD.
REQ-029 In HOLD, rvalid_o, rdata_o and err_o SHALL stay stable and gnt_o SHALL be 0 until rready_i=1.
REQ-030 When rready_i=1 and a new request is granted in the same cycle, the FSM SHALL produce back-to-back responses with no bubble.
REQ-031 When rready_i=1 and no request is granted, rvalid_o SHALL drop in the next cycle.

Reset
REQ-032 While rst=1, rvalid_o, err_o, gnt_o and init_done_o SHALL be 0, and rdata_o SHALL be 0.
REQ-033 On rst, the fill counter SHALL clear and the FSM SHALL enter INIT.
REQ-034 Reset asserted mid-operation SHALL drop any pending response, re-run INIT, and leave the array contents unspecified until the fill completes.

Structure
REQ-035 Package sram_ctrl_pkg SHALL hold the state enum (INIT, READY, HOLD) and the localparam for the byte-lane count.
REQ-036 The storage SHALL be the sub-module sram_array, providing a synchronous registered read, a per-byte write enable and one read/write port.
REQ-037 sram_ctrl SHALL contain the FSM, the fill counter, range checking and the response register.

Verification
REQ-038 Reset, DATA_W=32, DEPTH=16, INIT_CLEAR=1 -> init_done_o rises exactly 16 cycles after rst falls; reads of words 0..15 return 0x00000000.
REQ-039 Write 0xDEADBEEF to addr 0x8 with be_i=4'b1111, then write 0x000000AA to addr 0x8 with be_i=4'b0001, then read 0x8 -> rdata_o=0xDEADBEAA.
REQ-040 Write 0x12345678 to 0x4 then read 0x4 on the next cycle, rready_i=1 -> two consecutive rvalid_o cycles; second rdata_o=0x12345678.
REQ-041 Read 0x4 with rready_i held at 0 for 3 cycles, req_i held at 1 -> gnt_o=0 and rdata_o stable for those cycles; next grant issues in the cycle rready_i rises.
REQ-042 Read addr 0x40 (index 16) with DEPTH=16 -> rvalid_o=1, err_o=1, rdata_o=0; a following read of 0x0 returns unchanged data.
REQ-043 Assert rst while a response is in HOLD -> rvalid_o=0 in the next cycle; init_done_o=0 until the fill completes again.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and constants for the SRAM controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  // Controller states: array fill, idle/streaming, and stalled response.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of one byte lane in bits.
  localparam int BYTE_W = 8;

  // Byte-lane count for the default 32-bit word.
  localparam int DEF_LANES = 32 / BYTE_W;

  // Byte-lane count for an arbitrary data width.
  function automatic int lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_array
// Description : Single-port word array with per-byte write enables and a
//               registered read output.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [DATA_W/8-1:0]    be_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o
);

  localparam int LANES = lanes(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write, or registered read; the read register holds its value
  // whenever the port is idle so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int l = 0; l < LANES; l++) begin
          if (be_i[l]) begin
            mem_q[idx_i][l*BYTE_W +: BYTE_W] <= wdata_i[l*BYTE_W +: BYTE_W];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Request/response front end for sram_array: post-reset zero
//               fill, range checking, 1-cycle response with back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4096,
  parameter int ADDR_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  input  logic                  rready_i,
  output logic                  init_done_o
);

  localparam int LANES = lanes(DATA_W);
  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fill_q, fill_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;     // response carries array read data

  logic [IDX_W-1:0]  req_idx;
  logic              oor;
  logic              init_done;
  logic              gnt;

  logic              arr_en;
  logic              arr_we;
  logic [LANES-1:0]  arr_be;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign req_idx = addr_i[OFF_W +: IDX_W];

  // Any set bit above the in-range index field marks the word out of range.
  generate
    if (ADDR_W > OFF_W + IDX_W) begin : g_range_hi
      assign oor = |addr_i[ADDR_W-1:OFF_W+IDX_W];
    end else begin : g_range_full
      assign oor = 1'b0;
    end
  endgenerate

  // Sub-word address bits select nothing; fold them into an ignored net.
  generate
    if (OFF_W > 0) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^addr_i[OFF_W-1:0];
    end
  endgenerate

  // Outputs are forced idle while reset is held, independent of flop state.
  assign init_done   = (state_q != INIT) && !rst;
  assign init_done_o = init_done;
  assign gnt         = req_i && init_done && (!rvalid_q || rready_i);
  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q && !rst;
  assign err_o       = err_q && rvalid_o;
  assign rdata_o     = (rvalid_o && rd_q) ? arr_rdata : '0;

  // Next-state, fill counter, response register and array port steering.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    rvalid_d  = rvalid_q;
    err_d     = err_q;
    rd_d      = rd_q;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_idx   = req_idx;
    arr_wdata = data_i;

    case (state_q)
      INIT: begin
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rd_d     = 1'b0;
        fill_d   = fill_q + IDX_W'(1);
        if (INIT_CLEAR != 0) begin
          arr_en    = 1'b1;
          arr_we    = 1'b1;
          arr_be    = '1;
          arr_idx   = fill_q;
          arr_wdata = '0;
        end
        if ((INIT_CLEAR == 0) || (fill_q == LAST_IDX)) begin
          state_d = READY;
        end
      end
      default: begin
        if (gnt) begin
          rvalid_d = 1'b1;
          err_d    = oor;
          rd_d     = !we_i && !oor;
          arr_en   = !oor;
          arr_we   = we_i;
          arr_be   = be_i;
        end else if (rready_i) begin
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          rd_d     = 1'b0;
        end
        state_d = (rvalid_q && !rready_i) ? HOLD : READY;
      end
    endcase
  end

  // State register with synchronous reset back into the fill phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      fill_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en && !rst),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

endmodule
`default_nettype wire
